// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Function : Common-data-bus arbiter. Each producer writes into a private
//            FIFO. One result per cycle is chosen round-robin and broadcast
//            on a registered CDB (valid, data, ROB tag, source index).
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int QDEPTH  = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           flush,
  input  logic [NUM_SRC-1:0]                             src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]                      src_data,
  input  logic [NUM_SRC*TAG_W-1:0]                       src_tag,
  output logic [NUM_SRC-1:0]                             src_ready,
  output logic                                           cdb_valid,
  output logic [DATA_W-1:0]                              cdb_data,
  output logic [TAG_W-1:0]                               cdb_tag,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] cdb_src
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] C_QDEPTH = CW'(QDEPTH);
  localparam logic [SW-1:0] C_LAST   = SW'(NUM_SRC - 1);
  localparam logic [PW-1:0] C_PLAST  = PW'(QDEPTH - 1);

  // Per-source queue status and head entries, gathered for the arbiter.
  logic [NUM_SRC-1:0] w_nonempty;
  logic [DATA_W-1:0]  w_head_data [NUM_SRC];
  logic [TAG_W-1:0]   w_head_tag  [NUM_SRC];

  // Arbitration result.
  logic               w_found;
  logic [SW-1:0]      w_win;

  // Round-robin pointer and registered CDB.
  logic [SW-1:0]      r_rr;
  logic               r_cdb_valid;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [SW-1:0]      r_cdb_src;

  // Source index base+k, folded back into 0..NUM_SRC-1.
  function automatic logic [SW-1:0] rr_offset(input logic [SW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return SW'(s);
  endfunction

  // Source index following p, wrapping at NUM_SRC.
  function automatic logic [SW-1:0] rr_inc(input logic [SW-1:0] p);
    if (p == C_LAST) return '0;
    return p + 1'b1;
  endfunction

  // Queue pointer following p, wrapping at QDEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == C_PLAST) return '0;
    return p + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    localparam logic [SW-1:0] C_IDX = SW'(gi);

    logic [DATA_W-1:0] r_dmem [QDEPTH];
    logic [TAG_W-1:0]  r_tmem [QDEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    // Ready looks only at the registered count, so a same-cycle pop never raises it.
    assign src_ready[gi]   = (r_count < C_QDEPTH);
    assign w_push          = src_valid[gi] & src_ready[gi];
    assign w_pop           = w_found & (w_win == C_IDX);
    assign w_nonempty[gi]  = (r_count != '0);
    assign w_head_data[gi] = r_dmem[r_head];
    assign w_head_tag[gi]  = r_tmem[r_head];

    // Queue pointers and occupancy; flush empties the queue ahead of any push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= ptr_inc(r_tail);
        if (w_pop)  r_head <= ptr_inc(r_head);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // Entry storage; contents are meaningful only below the count, so no reset.
    always_ff @(posedge clk) begin
      if (w_push && !flush) begin
        r_dmem[r_tail] <= src_data[gi*DATA_W +: DATA_W];
        r_tmem[r_tail] <= src_tag[gi*TAG_W +: TAG_W];
      end
    end
  end

  // Round-robin search: first non-empty queue starting at r_rr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_found && w_nonempty[rr_offset(r_rr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_offset(r_rr, k);
      end
    end
  end

  // CDB broadcast register and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr        <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_data  <= '0;
      r_cdb_tag   <= '0;
      r_cdb_src   <= '0;
    end else if (flush) begin
      r_rr        <= '0;
      r_cdb_valid <= 1'b0;
    end else begin
      r_cdb_valid <= w_found;
      if (w_found) begin
        r_cdb_data <= w_head_data[w_win];
        r_cdb_tag  <= w_head_tag[w_win];
        r_cdb_src  <= w_win;
        r_rr       <= rr_inc(w_win);
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_data  = r_cdb_data;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_src   = r_cdb_src;

endmodule
`default_nettype wire
